// File: rtl/cbfp_stream_module.sv
// cbfp_stream_module: streaming block-floating-point normaliser with a ping-pong block buffer,
// per-block exponent search and a registered valid/ready output stage.
module cbfp_stream_module #(
    parameter int IN_W        = 25,
    parameter int OUT_W       = 12,
    parameter int NCHAN       = 16,
    parameter int BLOCK_SIZE  = 8,
    parameter int TRUNC_VALUE = 13,
    parameter int SAT_EN      = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    valid_in,
    output logic                                    ready_in,
    input  logic [NCHAN-1:0][IN_W-1:0]              data_re_in,
    input  logic [NCHAN-1:0][IN_W-1:0]              data_im_in,
    output logic                                    valid_out,
    input  logic                                    ready_out,
    output logic [NCHAN-1:0][OUT_W-1:0]             data_re_out,
    output logic [NCHAN-1:0][OUT_W-1:0]             data_im_out,
    output logic [NCHAN-1:0][$clog2(IN_W)-1:0]      idx_out,
    output logic                                    last_out,
    output logic                                    sat_out
);
    localparam int IDX_W = $clog2(IN_W);
    localparam int GRP   = NCHAN / BLOCK_SIZE > 1 ? NCHAN / BLOCK_SIZE : 1;
    localparam int BEATS = BLOCK_SIZE / NCHAN > 1 ? BLOCK_SIZE / NCHAN : 1;
    localparam int GSZ   = NCHAN / GRP;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;

    generate
        if (NCHAN % BLOCK_SIZE != 0 && BLOCK_SIZE % NCHAN != 0) begin : g_bad_block
            $error("BLOCK_SIZE must divide NCHAN or be a multiple of it");
        end
    endgenerate

    function automatic logic [IDX_W-1:0] lz(input logic [IN_W-1:0] x);
        logic [IDX_W-1:0] n;
        logic run;
        n   = '0;
        run = 1'b1;
        for (int i = IN_W - 2; i >= 0; i--) begin
            run = run & (x[i] == x[IN_W-1]);
            n   = n + IDX_W'(run);
        end
        return n;
    endfunction

    // Returns {clipped, value}; a left shift by at most e never overflows IN_W bits.
    function automatic logic [OUT_W:0] fmt(input logic [IN_W-1:0] x, input logic [IDX_W-1:0] e);
        int ei, yi;
        logic signed [IN_W-1:0] y;
        ei = int'(e);
        y  = ei > TRUNC_VALUE ? $signed(x) <<< (ei - TRUNC_VALUE) : $signed(x) >>> (TRUNC_VALUE - ei);
        yi = int'(y);
        if (SAT_EN != 0 && yi > 2 ** (OUT_W - 1) - 1) return {2'b10, {(OUT_W-1){1'b1}}};
        if (SAT_EN != 0 && yi < -(2 ** (OUT_W - 1))) return {2'b11, {(OUT_W-1){1'b0}}};
        return {1'b0, y[OUT_W-1:0]};
    endfunction

    logic [NCHAN-1:0][IN_W-1:0]  mem_re [2][BEATS];
    logic [NCHAN-1:0][IN_W-1:0]  mem_im [2][BEATS];
    logic [GRP-1:0][IDX_W-1:0]   blk_exp [2];
    logic [GRP-1:0][IDX_W-1:0]   gmin, run_min;
    logic                        wr_bank, rd_bank, acc, load, wr_last, rd_last, nsat;
    logic [BW-1:0]               wr_beat, rd_beat;
    logic [1:0]                  full;
    logic [NCHAN-1:0][OUT_W-1:0] nre, nim;
    logic [NCHAN-1:0][IDX_W-1:0] nidx;
    logic [OUT_W:0]              fr, fi;

    assign ready_in = !full[wr_bank] && !rst;
    assign acc      = valid_in && ready_in;
    assign load     = full[rd_bank] && (!valid_out || ready_out);
    assign wr_last  = wr_beat == BW'(BEATS - 1);
    assign rd_last  = rd_beat == BW'(BEATS - 1);

    always_comb begin
        for (int g = 0; g < GRP; g++) gmin[g] = wr_beat == '0 ? IDX_W'(IN_W - 1) : run_min[g];
        for (int c = 0; c < NCHAN; c++) begin
            if (lz(data_re_in[c]) < gmin[c/GSZ]) gmin[c/GSZ] = lz(data_re_in[c]);
            if (lz(data_im_in[c]) < gmin[c/GSZ]) gmin[c/GSZ] = lz(data_im_in[c]);
        end
    end

    always_comb begin
        nsat = 1'b0;
        fr   = '0;
        fi   = '0;
        for (int c = 0; c < NCHAN; c++) begin
            nidx[c] = blk_exp[rd_bank][c/GSZ];
            fr      = fmt(mem_re[rd_bank][rd_beat][c], nidx[c]);
            fi      = fmt(mem_im[rd_bank][rd_beat][c], nidx[c]);
            nre[c]  = fr[OUT_W-1:0];
            nim[c]  = fi[OUT_W-1:0];
            nsat    = nsat | fr[OUT_W] | fi[OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            mem_re[wr_bank][wr_beat] <= data_re_in;
            mem_im[wr_bank][wr_beat] <= data_im_in;
            if (wr_last) blk_exp[wr_bank] <= gmin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_beat     <= '0;
            rd_beat     <= '0;
            full        <= '0;
            run_min     <= '0;
            valid_out   <= 1'b0;
            last_out    <= 1'b0;
            sat_out     <= 1'b0;
            data_re_out <= '0;
            data_im_out <= '0;
            idx_out     <= '0;
        end else begin
            if (acc) begin
                run_min <= gmin;
                wr_beat <= wr_last ? '0 : wr_beat + 1'b1;
                if (wr_last) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                end
            end
            // A bank being read is always full, so it never collides with the bank being written.
            if (load) begin
                data_re_out <= nre;
                data_im_out <= nim;
                idx_out     <= nidx;
                sat_out     <= nsat;
                last_out    <= rd_last;
                valid_out   <= 1'b1;
                rd_beat     <= rd_last ? '0 : rd_beat + 1'b1;
                if (rd_last) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                end
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end
endmodule
